// File: rtl/dcache_loadpipe_l2_pkg.sv
// Shared dcache definitions: load-pipe FSM states, address widths and
// line-offset constants used by the stage-2 load pipeline.
package dcache_loadpipe_l2_pkg;

    localparam int VADDR_W    = 32;
    localparam int LINE_OFF_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        WAIT_REFILL,
        REPLAY
    } lp_state_e;

    function automatic logic [VADDR_W-1:0] line_base(
        input logic [VADDR_W-1:0] addr,
        input int                 low
    );
        logic [VADDR_W-1:0] r;
        r = addr;
        for (int i = 0; i < VADDR_W; i++) begin
            if (i < low) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_loadpipe_l2_if.sv
// Stage-2 load pipe bus: stage-1 request, tag/data array ports,
// miss/refill handshake and load-unit response.
interface dcache_loadpipe_l2_if #(
    parameter int WAYS      = 4,
    parameter int TAG_WIDTH = 20,
    parameter int IDX_W     = 6
) ();
    import dcache_loadpipe_l2_pkg::*;

    logic                      flush;
    logic                      s1_req_valid;
    logic                      s1_req_ready;
    logic [VADDR_W-1:0]        s1_req_vaddr;
    logic [WAYS*TAG_WIDTH-1:0] tagarray_rd_tag;
    logic [WAYS-1:0]           tagarray_rd_vld;
    logic                      dataarray_rd_en;
    logic [IDX_W-1:0]          dataarray_rd_idx;
    logic [WAYS-1:0]           dataarray_rd_way;
    logic                      miss_req_valid;
    logic                      miss_req_ready;
    logic [VADDR_W-1:0]        miss_req_paddr;
    logic                      refill_done;
    logic                      resp_valid;
    logic                      resp_hit;
    logic                      resp_replay;
    logic [VADDR_W-1:0]        resp_vaddr;

    modport master (
        input  flush, s1_req_valid, s1_req_vaddr,
        input  tagarray_rd_tag, tagarray_rd_vld,
        input  miss_req_ready, refill_done,
        output s1_req_ready,
        output dataarray_rd_en, dataarray_rd_idx, dataarray_rd_way,
        output miss_req_valid, miss_req_paddr,
        output resp_valid, resp_hit, resp_replay, resp_vaddr
    );

    modport slave (
        output flush, s1_req_valid, s1_req_vaddr,
        output tagarray_rd_tag, tagarray_rd_vld,
        output miss_req_ready, refill_done,
        input  s1_req_ready,
        input  dataarray_rd_en, dataarray_rd_idx, dataarray_rd_way,
        input  miss_req_valid, miss_req_paddr,
        input  resp_valid, resp_hit, resp_replay, resp_vaddr
    );

endinterface

// File: rtl/dcache_tag_compare.sv
// Per-way tag match and lowest-index way select; purely combinational.
module dcache_tag_compare #(
    parameter int WAYS      = 4,
    parameter int TAG_WIDTH = 20
) (
    input  logic [WAYS*TAG_WIDTH-1:0] rd_tag,
    input  logic [WAYS-1:0]           rd_vld,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      hit,
    output logic [WAYS-1:0]           hit_way
);

    logic [WAYS-1:0] hit_vec;
    logic            found;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        found   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            hit_vec[i] = rd_vld[i] &&
                         (rd_tag[i*TAG_WIDTH +: TAG_WIDTH] == req_tag);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec[i] && !found) begin
                hit_way[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign hit = |hit_vec;

endmodule

// File: rtl/dcache_loadpipe_l2.sv
// Load pipeline stage 2: tag compare with same-cycle hit response,
// plus a miss FSM that requests a line fill and replays the load.
module dcache_loadpipe_l2
    import dcache_loadpipe_l2_pkg::*;
#(
    parameter int WAYS               = 4,
    parameter int TAG_WIDTH          = 20,
    parameter int TAG_ARRAY_IDX_HIGH = 11,
    parameter int TAG_ARRAY_IDX_LOW  = LINE_OFF_W
) (
    input logic                  clock,
    input logic                  reset,
    dcache_loadpipe_l2_if.master bus
);

    localparam int IDX_W = TAG_ARRAY_IDX_HIGH - TAG_ARRAY_IDX_LOW + 1;

    lp_state_e          state_q, state_d;
    logic               s2_valid_q, s2_valid_d;
    logic [VADDR_W-1:0] s2_vaddr_q, s2_vaddr_d;
    logic               cancel_q, cancel_d;

    logic [TAG_WIDTH-1:0] req_tag;
    logic                 hit;
    logic [WAYS-1:0]      hit_way;
    logic                 in_idle;
    logic                 hit_fire;
    logic                 miss_det;
    logic                 replay_fire;
    logic                 accept;

    assign req_tag = s2_vaddr_q[TAG_ARRAY_IDX_HIGH+TAG_WIDTH:TAG_ARRAY_IDX_HIGH+1];

    dcache_tag_compare #(
        .WAYS     (WAYS),
        .TAG_WIDTH(TAG_WIDTH)
    ) u_tag_cmp (
        .rd_tag (bus.tagarray_rd_tag),
        .rd_vld (bus.tagarray_rd_vld),
        .req_tag(req_tag),
        .hit    (hit),
        .hit_way(hit_way)
    );

    assign in_idle     = (state_q == IDLE);
    assign hit_fire    = in_idle && s2_valid_q && hit && !bus.flush;
    assign miss_det    = in_idle && s2_valid_q && !hit;
    assign replay_fire = (state_q == REPLAY) && !bus.flush;

    // A missing s2 load must not be overwritten by a new capture.
    assign bus.s1_req_ready = !reset && in_idle && !bus.flush && !miss_det;
    assign accept = bus.s1_req_valid && bus.s1_req_ready;

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        s2_valid_d = 1'b0;
        s2_vaddr_d = s2_vaddr_q;
        if (accept) begin
            s2_valid_d = 1'b1;
            s2_vaddr_d = bus.s1_req_vaddr;
        end
        unique case (state_q)
            IDLE: begin
                if (miss_det && !bus.flush) begin
                    state_d    = MISS_REQ;
                    s2_valid_d = 1'b1;
                end
            end
            MISS_REQ: begin
                s2_valid_d = s2_valid_q && !bus.flush;
                if (bus.miss_req_ready) begin
                    state_d  = WAIT_REFILL;
                    cancel_d = bus.flush;
                end else if (bus.flush) begin
                    state_d = IDLE;
                end
            end
            WAIT_REFILL: begin
                s2_valid_d = s2_valid_q && !bus.flush;
                if (bus.refill_done) begin
                    state_d  = (cancel_q || bus.flush) ? IDLE : REPLAY;
                    cancel_d = 1'b0;
                end else if (bus.flush) begin
                    cancel_d = 1'b1;
                end
            end
            REPLAY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s2_valid_q <= 1'b0;
            s2_vaddr_q <= '0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s2_valid_q <= s2_valid_d;
            s2_vaddr_q <= s2_vaddr_d;
            cancel_q   <= cancel_d;
        end
    end

    assign bus.dataarray_rd_en  = hit_fire;
    assign bus.dataarray_rd_idx = hit_fire ?
        s2_vaddr_q[TAG_ARRAY_IDX_HIGH:TAG_ARRAY_IDX_LOW] : IDX_W'(0);
    assign bus.dataarray_rd_way = hit_fire ? hit_way : '0;

    assign bus.miss_req_valid = (state_q == MISS_REQ);
    assign bus.miss_req_paddr = bus.miss_req_valid ?
        line_base(s2_vaddr_q, TAG_ARRAY_IDX_LOW) : '0;

    assign bus.resp_valid  = hit_fire || replay_fire;
    assign bus.resp_hit    = hit_fire;
    assign bus.resp_replay = replay_fire;
    assign bus.resp_vaddr  = bus.resp_valid ? s2_vaddr_q : '0;

endmodule

// File: tb/tb_dcache_loadpipe_l2.sv
// Bench for dcache_loadpipe_l2: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_dcache_loadpipe_l2;
    import dcache_loadpipe_l2_pkg::*;

    localparam int WAYS = 4;
    localparam int TW   = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    dcache_loadpipe_l2_if #(.WAYS(WAYS), .TAG_WIDTH(TW), .IDX_W(6)) bus ();

    dcache_loadpipe_l2 #(
        .WAYS              (WAYS),
        .TAG_WIDTH         (TW),
        .TAG_ARRAY_IDX_HIGH(11),
        .TAG_ARRAY_IDX_LOW (6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one load in flight, tracked as flags for "miss not yet sent",
    // "waiting for fill", "replay due now" and "load was killed".
    bit          m_has, m_req, m_wait, m_replay, m_cancel;
    logic [31:0] m_addr;

    function automatic int hit_way_of(input logic [31:0] a);
        for (int i = 0; i < WAYS; i++) begin
            if (bus.tagarray_rd_vld[i] &&
                bus.tagarray_rd_tag[i*TW +: TW] == a[31:12]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_idle();
        return !(m_req || m_wait || m_replay);
    endfunction

    function automatic bit exp_ready();
        return !reset && m_idle() && !bus.flush &&
               !(m_has && hit_way_of(m_addr) < 0);
    endfunction

    always @(posedge clock or posedge reset) begin : model
        bit acc;
        int hw;
        if (reset) begin
            m_has = 0; m_req = 0; m_wait = 0; m_replay = 0; m_cancel = 0;
            m_addr = '0;
        end else begin
            acc = bus.s1_req_valid && exp_ready();
            hw  = hit_way_of(m_addr);
            if (m_idle()) begin
                if (m_has && hw < 0 && !bus.flush) begin
                    m_req = 1;
                end else begin
                    m_has = acc;
                    if (acc) m_addr = bus.s1_req_vaddr;
                end
            end else if (m_req) begin
                if (bus.miss_req_ready) begin
                    m_req = 0; m_wait = 1; m_cancel = bus.flush;
                end else if (bus.flush) begin
                    m_req = 0;
                end
                if (bus.flush) m_has = 0;
            end else if (m_wait) begin
                if (bus.refill_done) begin
                    m_wait   = 0;
                    m_replay = !(m_cancel || bus.flush);
                    m_cancel = 0;
                    if (!m_replay) m_has = 0;
                end else if (bus.flush) begin
                    m_cancel = 1; m_has = 0;
                end
            end else begin
                m_replay = 0; m_has = 0;
            end
        end
    end

    always @(negedge clock) begin : compare
        int          hw;
        bit          rd, rp;
        logic [31:0] pa;
        if (chk_en) begin
            hw = (m_idle() && m_has) ? hit_way_of(m_addr) : -1;
            rd = (hw >= 0) && !bus.flush;
            rp = m_replay && !bus.flush;
            pa = m_addr & ~32'h3f;
            chk("rd_en", 64'(bus.dataarray_rd_en), 64'(rd));
            chk("rd_way", 64'(bus.dataarray_rd_way), rd ? (64'(1) << hw) : 64'(0));
            chk("rd_idx", 64'(bus.dataarray_rd_idx), rd ? 64'(m_addr[11:6]) : 64'(0));
            chk("miss_valid", 64'(bus.miss_req_valid), 64'(m_req));
            chk("miss_paddr", 64'(bus.miss_req_paddr), m_req ? 64'(pa) : 64'(0));
            chk("resp_valid", 64'(bus.resp_valid), 64'(rd || rp));
            chk("resp_hit", 64'(bus.resp_hit), 64'(rd));
            chk("resp_replay", 64'(bus.resp_replay), 64'(rp));
            chk("resp_vaddr", 64'(bus.resp_vaddr), (rd || rp) ? 64'(m_addr) : 64'(0));
            chk("s1_ready", 64'(bus.s1_req_ready), 64'(exp_ready()));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_in();
        bus.flush           = 1'b0;
        bus.s1_req_valid    = 1'b0;
        bus.s1_req_vaddr    = '0;
        bus.tagarray_rd_tag = '0;
        bus.tagarray_rd_vld = '0;
        bus.miss_req_ready  = 1'b0;
        bus.refill_done     = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] r;
        logic [31:0] mt;
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;
        #3;
        chk("rst_ready", 64'(bus.s1_req_ready), 64'(1));
        chk("rst_resp", 64'(bus.resp_valid), 64'(0));
        chk("rst_miss", 64'(bus.miss_req_valid), 64'(0));

        // Hit in way 2 (way 0 matches but is invalid)
        step();
        bus.s1_req_valid = 1'b1;
        bus.s1_req_vaddr = 32'h1040;
        step();
        bus.s1_req_vaddr    = 32'h3000;
        bus.tagarray_rd_tag = {20'h00abc, 20'h00001, 20'h00def, 20'h00001};
        bus.tagarray_rd_vld = 4'b0100;
        #3;
        chk("hit_valid", 64'(bus.resp_valid), 64'(1));
        chk("hit_hit", 64'(bus.resp_hit), 64'(1));
        chk("hit_way2", 64'(bus.dataarray_rd_way), 64'(4'b0100));
        chk("hit_idx", 64'(bus.dataarray_rd_idx), 64'(1));
        chk("hit_vaddr", 64'(bus.resp_vaddr), 64'(32'h1040));

        // Ways 1 and 3 both hit
        step();
        bus.s1_req_valid    = 1'b0;
        bus.tagarray_rd_tag = {20'h00003, 20'h00005, 20'h00003, 20'h00003};
        bus.tagarray_rd_vld = 4'b1010;
        #3;
        chk("multi_way", 64'(bus.dataarray_rd_way), 64'(4'b0010));

        // Miss with miss_req_ready low for three cycles
        step();
        bus.s1_req_valid    = 1'b1;
        bus.s1_req_vaddr    = 32'h2078;
        bus.tagarray_rd_vld = '0;
        step();
        bus.s1_req_vaddr = 32'h7777_7000;
        #3;
        chk("miss_det_ready", 64'(bus.s1_req_ready), 64'(0));
        for (int k = 0; k < 4; k++) begin
            step();
            bus.miss_req_ready = (k == 3);
            #3;
            chk("miss_paddr_lit", 64'(bus.miss_req_paddr), 64'(32'h2040));
            chk("miss_vld_lit", 64'(bus.miss_req_valid), 64'(1));
            chk("miss_ready_lit", 64'(bus.s1_req_ready), 64'(0));
        end
        step();
        bus.s1_req_valid   = 1'b0;
        bus.miss_req_ready = 1'b0;
        #3;
        chk("wait_no_miss", 64'(bus.miss_req_valid), 64'(0));
        step();
        bus.refill_done = 1'b1;
        step();
        bus.refill_done = 1'b0;
        #3;
        chk("replay_flag", 64'(bus.resp_replay), 64'(1));
        chk("replay_vaddr", 64'(bus.resp_vaddr), 64'(32'h2078));
        chk("replay_hit", 64'(bus.resp_hit), 64'(0));
        step();
        bus.refill_done = 1'b1;
        #3;
        chk("post_replay_valid", 64'(bus.resp_valid), 64'(0));
        chk("post_replay_ready", 64'(bus.s1_req_ready), 64'(1));

        // Flush while waiting for refill cancels the replay
        step();
        bus.refill_done  = 1'b0;
        bus.s1_req_valid = 1'b1;
        bus.s1_req_vaddr = 32'h5000;
        step();
        bus.s1_req_valid = 1'b0;
        step();
        bus.miss_req_ready = 1'b1;
        step();
        bus.miss_req_ready = 1'b0;
        bus.flush          = 1'b1;
        #3;
        chk("flush_wait_resp", 64'(bus.resp_valid), 64'(0));
        step();
        bus.flush       = 1'b0;
        bus.refill_done = 1'b1;
        step();
        bus.refill_done = 1'b0;
        #3;
        chk("cancel_no_resp", 64'(bus.resp_valid), 64'(0));
        chk("cancel_idle", 64'(bus.s1_req_ready), 64'(1));

        // Asynchronous reset in MISS_REQ
        step();
        bus.s1_req_valid = 1'b1;
        bus.s1_req_vaddr = 32'h6000;
        step();
        bus.s1_req_valid = 1'b0;
        step();
        #3;
        chk("pre_rst_miss", 64'(bus.miss_req_valid), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_miss", 64'(bus.miss_req_valid), 64'(0));
        step();
        reset = 1'b0;
        #3;
        chk("rst_release_ready", 64'(bus.s1_req_ready), 64'(1));

        // Random traffic
        repeat (3000) begin
            step();
            mt = m_addr;
            bus.s1_req_valid = ($urandom_range(0, 1) == 1);
            r = $urandom;
            bus.s1_req_vaddr = ($urandom_range(0, 3) == 0) ? mt : r;
            for (int i = 0; i < WAYS; i++) begin
                r = $urandom;
                bus.tagarray_rd_tag[i*TW +: TW] =
                    ($urandom_range(0, 2) == 0) ? mt[31:12] : r[19:0];
            end
            r = $urandom;
            bus.tagarray_rd_vld = r[3:0];
            bus.flush          = ($urandom_range(0, 15) == 0);
            bus.miss_req_ready = ($urandom_range(0, 2) == 0);
            bus.refill_done    = ($urandom_range(0, 3) == 0);
        end
        step();
        idle_in();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_loadpipe_l2.md
DCACHE_LOADPIPE_L2 -- requirements
Module: dcache_loadpipe_l2

Interface
REQ-001 SHALL have parameter WAYS, default 4: number of cache ways.
REQ-002 SHALL have parameter TAG_WIDTH, default 20: stored tag width.
REQ-003 SHALL have parameters TAG_ARRAY_IDX_HIGH, default 11, and TAG_ARRAY_IDX_LOW, default 6: set-index bit range.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: kill in-flight load.
REQ-007 SHALL have s1_req_valid input 1, s1_req_ready output 1, s1_req_vaddr input `VADDR_RANGE: request from stage 1.
REQ-008 SHALL have tagarray_rd_tag input WAYS*TAG_WIDTH and tagarray_rd_vld input WAYS: tag read data, valid the cycle after stage-1 issue.
REQ-009 SHALL have dataarray_rd_en output 1, dataarray_rd_idx output index width, dataarray_rd_way output WAYS: one-hot data-array read.
REQ-010 SHALL have miss_req_valid output 1, miss_req_ready input 1, miss_req_paddr output `VADDR_RANGE: line-fill request.
REQ-011 SHALL have refill_done input 1: line for outstanding miss installed.
REQ-012 SHALL have resp_valid output 1, resp_hit output 1, resp_replay output 1, resp_vaddr output `VADDR_RANGE: response to load unit.

Function
REQ-013 SHALL capture s1_req_vaddr into the s2 register and set s2_valid when s1_req_valid && s1_req_ready; otherwise SHALL clear s2_valid, except while held by the FSM.
REQ-014 SHALL drive s1_req_ready = 1 only in state IDLE with flush low.
REQ-015 SHALL compute req_tag = s2_vaddr[TAG_ARRAY_IDX_HIGH+TAG_WIDTH : TAG_ARRAY_IDX_HIGH+1]; way i hits when tagarray_rd_vld[i] and tag i equals req_tag.
REQ-016 SHALL resolve multiple hitting ways to the lowest-indexed way.
REQ-017 SHALL, on a hit with s2_valid in IDLE, assert dataarray_rd_en, dataarray_rd_idx = s2 index, one-hot dataarray_rd_way, resp_valid=1, resp_hit=1, resp_replay=0, resp_vaddr = s2_vaddr in that same cycle (zero added latency).
REQ-018 SHALL implement FSM states IDLE, MISS_REQ, WAIT_REFILL, REPLAY.
REQ-019 SHALL transition IDLE->MISS_REQ on s2_valid with no hit, holding s2_vaddr.
REQ-020 SHALL in MISS_REQ hold miss_req_valid=1 and miss_req_paddr = s2_vaddr with bits [TAG_ARRAY_IDX_LOW-1:0] zeroed, stable until miss_req_ready; then ->WAIT_REFILL.
REQ-021 SHALL in WAIT_REFILL go ->REPLAY on refill_done; a refill_done in any other state SHALL be ignored.
REQ-022 SHALL in REPLAY assert resp_valid=1, resp_hit=0, resp_replay=1, resp_vaddr = s2_vaddr for exactly one cycle, then ->IDLE.
REQ-023 SHALL on flush clear s2_valid and suppress resp_valid and dataarray_rd_en that cycle; MISS_REQ->IDLE only if miss_req_ready is low, otherwise ->WAIT_REFILL.
REQ-024 SHALL on flush in WAIT_REFILL stay there with the replay cancelled; the following refill_done SHALL then go ->IDLE with no response.
REQ-025 SHALL treat flush in REPLAY as suppression of the response; next state IDLE.

Reset
REQ-026 SHALL on reset force state IDLE, s2_valid=0, s2_vaddr=0, replay-cancel flag=0; all outputs SHALL be 0 except s1_req_ready=1 after reset deasserts.

Structure
REQ-027 SHALL place the FSM state enum and line-offset constants in the shared dcache package.
REQ-028 SHALL contain one sub-module, dcache_tag_compare: combinational hit vector plus lowest-way priority select.

Verification
REQ-029 Capture vaddr 0x1040, way 2 tag matches -> next cycle resp_valid=1, resp_hit=1, dataarray_rd_way=4'b0100, idx=1.
REQ-030 No hit on vaddr 0x2078, miss_req_ready held low 3 cycles -> miss_req_paddr=0x2040 stable 4 cycles, s1_req_ready=0.
REQ-031 Miss accepted, then refill_done -> exactly one cycle of resp_replay=1, resp_vaddr=0x2078, then s1_req_ready=1.
REQ-032 Ways 1 and 3 both hit -> dataarray_rd_way=4'b0010.
REQ-033 Flush in WAIT_REFILL, then refill_done -> no resp_valid; state IDLE.
REQ-034 Reset asserted mid-MISS_REQ, without a clock edge -> miss_req_valid=0 immediately; IDLE after release.
